// File: rtl/minirisc_acc_core.sv
// Multi-cycle accumulator core: register file, ten opcodes, carry/zero flags
// and a valid/ready instruction port. Each instruction walks IDLE->EXEC->WB->OUT.
module minirisc_acc_core #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  localparam int RSEL_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        op_i,
  input  logic [RSEL_W-1:0] rsel_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_out,
  output logic              result_valid,
  output logic              carry,
  output logic              zero,
  output logic              illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, OUT} state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_ADDR = 4'd3;
  localparam logic [3:0] OP_SUBR = 4'd4;
  localparam logic [3:0] OP_ANDR = 4'd5;
  localparam logic [3:0] OP_XORR = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_LD   = 4'd8;
  localparam logic [3:0] OP_CLR  = 4'd9;

  state_t              state, state_next;
  logic [3:0]          op_q;
  logic [RSEL_W-1:0]   rsel_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W:0]     tmp_q;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   regs [NREGS];

  // The top bit of the result carries the add carry-out or the subtract borrow.
  function automatic logic [DATA_W:0] alu(input logic [3:0] op,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] r,
                                          input logic [DATA_W-1:0] imm);
    logic [DATA_W:0] res;
    res = {1'b0, a};
    case (op)
      OP_LDI:  res = {1'b0, imm};
      OP_ADDI: res = {1'b0, a} + {1'b0, imm};
      OP_ADDR: res = {1'b0, a} + {1'b0, r};
      OP_SUBR: res = {1'b0, a} - {1'b0, r};
      OP_ANDR: res = {1'b0, a & r};
      OP_XORR: res = {1'b0, a ^ r};
      OP_LD:   res = {1'b0, r};
      OP_CLR:  res = '0;
      default: res = {1'b0, a};
    endcase
    return res;
  endfunction

  function automatic logic writes_acc(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_ST) && (op <= OP_CLR);
  endfunction

  function automatic logic writes_carry(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_ADDR) || (op == OP_SUBR) || (op == OP_CLR);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_CLR;
  endfunction

  always_comb begin
    state_next = state;
    if (ena) begin
      case (state)
        IDLE:    if (instr_valid) state_next = EXEC;
        EXEC:    state_next = WB;
        WB:      state_next = OUT;
        OUT:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign instr_ready  = (state == IDLE) && ena;
  assign result_valid = (state == OUT) && ena;
  assign illegal      = (state == WB) && ena && is_illegal(op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      rsel_q     <= '0;
      imm_q      <= '0;
      tmp_q      <= '0;
      acc        <= '0;
      result_out <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (ena) begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q   <= op_i;
            rsel_q <= rsel_i;
            imm_q  <= imm_i;
          end
        end
        EXEC: tmp_q <= alu(op_q, acc, regs[rsel_q], imm_q);
        // Commit; result_out is loaded here so it is stable during the OUT strobe.
        WB: begin
          result_out <= acc;
          if (!is_illegal(op_q)) begin
            if (writes_acc(op_q)) begin
              acc        <= tmp_q[DATA_W-1:0];
              result_out <= tmp_q[DATA_W-1:0];
              zero       <= (tmp_q[DATA_W-1:0] == '0);
            end
            if (writes_carry(op_q)) carry <= tmp_q[DATA_W];
            if (op_q == OP_ST) regs[rsel_q] <= acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minirisc_acc_core.sv
// Randomised bench for minirisc_acc_core against an arithmetic reference model,
// plus directed sequences for flags, illegal opcodes, enable stalls and reset.
module tb_minirisc_acc_core;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int M  = 1 << DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    op_i;
  logic [1:0]    rsel_i;
  logic [DW-1:0] imm_i;
  logic [DW-1:0] result_out;
  logic          result_valid;
  logic          carry;
  logic          zero;
  logic          illegal;

  int vectors = 0;
  int miscompares = 0;

  int m_acc;
  int m_regs [NR];
  int m_carry;
  int m_zero;
  int m_ill;

  minirisc_acc_core #(.DATA_W(DW), .NREGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .op_i(op_i), .rsel_i(rsel_i), .imm_i(imm_i),
    .result_out(result_out), .result_valid(result_valid), .carry(carry),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_acc = 0; m_carry = 0; m_zero = 0; m_ill = 0;
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
  endfunction

  function automatic void m_exec(input int op, input int rs, input int imm);
    int r;
    r = m_regs[rs];
    m_ill = 0;
    case (op)
      0: ;
      1: m_acc = imm;
      2: begin m_carry = (m_acc + imm >= M); m_acc = (m_acc + imm) % M; end
      3: begin m_carry = (m_acc + r >= M); m_acc = (m_acc + r) % M; end
      4: begin m_carry = (m_acc < r); m_acc = (m_acc - r + M) % M; end
      5: m_acc = m_acc & r;
      6: m_acc = m_acc ^ r;
      7: m_regs[rs] = m_acc;
      8: m_acc = r;
      9: begin m_acc = 0; m_carry = 0; end
      default: m_ill = 1;
    endcase
    if (op inside {1, 2, 3, 4, 5, 6, 8, 9}) m_zero = (m_acc == 0);
  endfunction

  task automatic issue(input int op, input int rs, input int imm, input int stall);
    int cyc;
    int ill;
    int w;
    @(negedge clk);
    op_i = op[3:0]; rsel_i = rs[1:0]; imm_i = imm[DW-1:0]; instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 20) begin @(negedge clk); w++; end
    if (!instr_ready) begin
      chk("accept_timeout", 0, 1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    op_i = 4'($urandom); rsel_i = 2'($urandom); imm_i = DW'($urandom);
    cyc = 1; ill = 0;
    if (stall > 0) begin
      ena = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        chk("stall_ready", instr_ready, 0);
        chk("stall_rvalid", result_valid, 0);
      end
      ena = 1'b1;
      cyc += stall;
    end
    while (!result_valid && cyc < 30) begin
      if (illegal) ill++;
      @(negedge clk);
      cyc++;
    end
    m_exec(op, rs, imm);
    chk("latency", cyc, 3 + stall);
    chk("busy_ready", instr_ready, 0);
    chk("result", result_out, m_acc);
    chk("carry", carry, m_carry);
    chk("zero", zero, m_zero);
    chk("illegal_pulse", ill, m_ill);
    @(negedge clk);
    chk("rvalid_once", result_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; instr_valid = 1'b0;
    op_i = '0; rsel_i = '0; imm_i = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_result", result_out, 0);
    chk("rst_rvalid", result_valid, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ready", instr_ready, 1);
    rst_n = 1'b1;

    issue(1, 0, 8'h12, 0);
    issue(1, 0, 8'hF0, 0);
    issue(2, 0, 8'h20, 0);
    issue(2, 0, 8'h00, 0);
    issue(1, 0, 8'h05, 0);
    issue(7, 2, 0, 0);
    issue(1, 0, 8'h03, 0);
    issue(4, 2, 0, 0);
    issue(8, 2, 0, 0);
    issue(6, 2, 0, 0);
    issue(1, 0, 8'h33, 0);
    issue(4'hC, 1, 8'hAA, 0);
    issue(9, 0, 0, 0);
    issue(1, 0, 8'h44, 5);

    // Reset arrives during the WB cycle of ST r1: the store must not land.
    issue(1, 0, 8'h7E, 0);
    @(negedge clk);
    op_i = 4'd7; rsel_i = 2'd1; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("midrst_result", result_out, 0);
    chk("midrst_carry", carry, 0);
    chk("midrst_zero", zero, 0);
    chk("midrst_rvalid", result_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8, 1, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int op;
      if ($urandom_range(0, 9) == 0) op = $urandom_range(10, 15);
      else op = $urandom_range(0, 9);
      issue(op, $urandom_range(0, NR - 1), $urandom_range(0, M - 1),
            ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
